// File: rtl/byte_receiver.sv
// Receive byte assembler: hunts for the sync byte in an LSB-first bit stream,
// then hands the first byte to the RX FSM as the PID and writes the rest to the RX FIFO.
module byte_receiver #(
    parameter logic [7:0]  SYNC_BYTE  = 8'h80,
    parameter int unsigned HUNT_LIMIT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_active,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       eop,
    input  logic       fifo_full,
    output logic [7:0] rx_byte,
    output logic       pid_valid,
    output logic       fifo_wr,
    output logic       sync_found,
    output logic       rx_error,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, HUNT, PID, DATA} state_t;

    localparam logic [7:0] HUNT_MAX = 8'(HUNT_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] hunt_cnt_q, hunt_cnt_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       pid_valid_q, pid_valid_d;
    logic       fifo_wr_q, fifo_wr_d;
    logic       sync_found_q, sync_found_d;
    logic       rx_error_q, rx_error_d;
    logic       overrun_q, overrun_d;

    logic [7:0] sr_next;
    logic [2:0] bit_inc;
    logic [7:0] hunt_inc;

    always_comb begin
        sr_next  = {bit_in, sr_q[7:1]};
        bit_inc  = bit_cnt_q + 3'd1;
        hunt_inc = hunt_cnt_q + 8'd1;

        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        hunt_cnt_d   = hunt_cnt_q;
        rx_byte_d    = rx_byte_q;
        overrun_d    = overrun_q;
        pid_valid_d  = 1'b0;
        fifo_wr_d    = 1'b0;
        sync_found_d = 1'b0;
        rx_error_d   = 1'b0;

        if (state_q != IDLE && !rx_active) begin
            // Aborted packet: drop everything in flight, keep the last byte and overrun flag.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rx_active) begin
                        state_d    = HUNT;
                        sr_d       = 8'd0;
                        bit_cnt_d  = 3'd0;
                        hunt_cnt_d = 8'd0;
                        overrun_d  = 1'b0;
                    end
                end
                HUNT: begin
                    if (bit_valid) begin
                        sr_d       = sr_next;
                        hunt_cnt_d = hunt_inc;
                        if (sr_next == SYNC_BYTE) begin
                            sync_found_d = 1'b1;
                            bit_cnt_d    = 3'd0;
                            state_d      = PID;
                        end else if (hunt_inc == HUNT_MAX) begin
                            rx_error_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                    if (eop) state_d = IDLE;
                end
                PID, DATA: begin
                    if (bit_valid) begin
                        sr_d      = sr_next;
                        bit_cnt_d = bit_inc;
                        if (bit_cnt_q == 3'd7) begin
                            rx_byte_d = sr_next;
                            if (state_q == PID) begin
                                pid_valid_d = 1'b1;
                                state_d     = DATA;
                            end else if (fifo_full) begin
                                overrun_d = 1'b1;
                            end else begin
                                fifo_wr_d = 1'b1;
                            end
                        end
                    end
                    // A byte completing on the same edge leaves bit_cnt_d at 0, so no error.
                    if (eop) begin
                        rx_error_d = (bit_cnt_d != 3'd0);
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sr_q         <= 8'd0;
            bit_cnt_q    <= 3'd0;
            hunt_cnt_q   <= 8'd0;
            rx_byte_q    <= 8'd0;
            pid_valid_q  <= 1'b0;
            fifo_wr_q    <= 1'b0;
            sync_found_q <= 1'b0;
            rx_error_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            hunt_cnt_q   <= hunt_cnt_d;
            rx_byte_q    <= rx_byte_d;
            pid_valid_q  <= pid_valid_d;
            fifo_wr_q    <= fifo_wr_d;
            sync_found_q <= sync_found_d;
            rx_error_q   <= rx_error_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_byte    = rx_byte_q;
    assign pid_valid  = pid_valid_q;
    assign fifo_wr    = fifo_wr_q;
    assign sync_found = sync_found_q;
    assign rx_error   = rx_error_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_byte_receiver.sv
// Scoreboard bench for byte_receiver: stimulus pushes expected pulses (kind, byte, cycle),
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_byte_receiver;

    localparam logic [3:0] K_SYNC = 4'b1000;
    localparam logic [3:0] K_PID  = 4'b0100;
    localparam logic [3:0] K_WR   = 4'b0010;
    localparam logic [3:0] K_ERR  = 4'b0001;

    typedef struct {
        logic [3:0] kind;
        logic [7:0] byt;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_active = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       eop = 1'b0;
    logic       fifo_full = 1'b0;
    logic [7:0] rx_byte;
    logic       pid_valid, fifo_wr, sync_found, rx_error, overrun;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    byte_receiver #(.SYNC_BYTE(8'h80), .HUNT_LIMIT(32)) dut (
        .clk(clk), .rst(rst), .rx_active(rx_active), .bit_valid(bit_valid),
        .bit_in(bit_in), .eop(eop), .fifo_full(fifo_full), .rx_byte(rx_byte),
        .pid_valid(pid_valid), .fifo_wr(fifo_wr), .sync_found(sync_found),
        .rx_error(rx_error), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any pulse must match the head of the queue in kind, byte and cycle.
    always @(negedge clk) begin
        logic [3:0] obs;
        obs = {sync_found, pid_valid, fifo_wr, rx_error};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            exp_t m;
            m = q.pop_front();
            chk("missed_pulse", 32'(obs), 32'(m.kind));
        end
        if (obs != 4'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'(obs), 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", 32'(obs), 32'(e.kind));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                if (e.kind == K_PID || e.kind == K_WR) chk("pulse_byte", 32'(rx_byte), 32'(e.byt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        eop       = 1'b0;
    endtask

    task automatic push(input logic [3:0] k, input logic [7:0] b);
        exp_t e;
        e.kind = k;
        e.byt  = b;
        e.cyc  = cyc + 1;
        q.push_back(e);
    endtask

    task automatic drive_bit(input logic b, input logic e, input logic [3:0] k, input logic [7:0] byt);
        bit_valid = 1'b1;
        bit_in    = b;
        eop       = e;
        if (k != 4'b0) push(k, byt);
        tick();
    endtask

    task automatic drive_eop(input logic [3:0] k);
        eop = 1'b1;
        if (k != 4'b0) push(k, 8'h00);
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v, input logic [3:0] k, input logic eop_last);
        for (int i = 0; i < 8; i++)
            drive_bit(v[i], eop_last && (i == 7), (i == 7) ? k : 4'b0, v);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) drive_bit(1'b0, 1'b0, 4'b0, 8'h00);
        drive_bit(1'b1, 1'b0, K_SYNC, 8'h00);
    endtask

    task automatic start_pkt();
        rx_active = 1'b1;
        tick();
    endtask

    task automatic end_pkt();
        rx_active = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset_outputs", {rx_byte, 3'b0, overrun, sync_found, pid_valid, fifo_wr, rx_error}, 32'h0);

        // Sync, PID A5, data 3C, eop on a byte boundary
        start_pkt();
        send_sync();
        send_byte(8'hA5, K_PID, 1'b0);
        send_byte(8'h3C, K_WR, 1'b0);
        drive_eop(4'b0);
        end_pkt();
        chk("rx_byte_hold_3c", 32'(rx_byte), 32'h3C);

        // FIFO full drops a byte and sets sticky overrun
        start_pkt();
        send_sync();
        send_byte(8'hA5, K_PID, 1'b0);
        fifo_full = 1'b1;
        send_byte(8'h12, 4'b0, 1'b0);
        fifo_full = 1'b0;
        chk("overrun_set", 32'(overrun), 32'h1);
        chk("rx_byte_dropped", 32'(rx_byte), 32'h12);
        drive_eop(4'b0);
        end_pkt();
        chk("overrun_sticky_idle", 32'(overrun), 32'h1);
        start_pkt();
        chk("overrun_cleared", 32'(overrun), 32'h0);

        // Partial byte at eop
        send_sync();
        send_byte(8'hC3, K_PID, 1'b0);
        drive_bit(1'b1, 1'b0, 4'b0, 8'h00);
        drive_bit(1'b0, 1'b0, 4'b0, 8'h00);
        drive_bit(1'b1, 1'b0, 4'b0, 8'h00);
        drive_bit(1'b1, 1'b0, 4'b0, 8'h00);
        drive_bit(1'b0, 1'b0, 4'b0, 8'h00);
        drive_eop(K_ERR);
        chk("rx_byte_after_partial", 32'(rx_byte), 32'hC3);
        tick();

        // Hunt timeout after 32 zero bits
        for (int i = 0; i < 31; i++) drive_bit(1'b0, 1'b0, 4'b0, 8'h00);
        drive_bit(1'b0, 1'b0, K_ERR, 8'h00);
        tick();

        // eop coincident with the 8th data bit: byte written, no error
        send_sync();
        send_byte(8'h5A, K_PID, 1'b0);
        send_byte(8'hFF, K_WR, 1'b1);
        chk("rx_byte_ff", 32'(rx_byte), 32'hFF);
        tick();

        // rx_active drop mid-byte: silent abort, rx_byte kept
        send_sync();
        send_byte(8'h11, K_PID, 1'b0);
        drive_bit(1'b1, 1'b0, 4'b0, 8'h00);
        drive_bit(1'b1, 1'b0, 4'b0, 8'h00);
        drive_bit(1'b1, 1'b0, 4'b0, 8'h00);
        rx_active = 1'b0;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        chk("rx_byte_abort_hold", 32'(rx_byte), 32'h11);

        // rst mid-byte clears everything
        start_pkt();
        send_sync();
        send_byte(8'h22, K_PID, 1'b0);
        fifo_full = 1'b1;
        send_byte(8'h33, 4'b0, 1'b0);
        fifo_full = 1'b0;
        chk("overrun_before_rst", 32'(overrun), 32'h1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 4'b0, 8'h00);
        rst = 1'b1;
        tick();
        chk("rst_mid_outputs", {rx_byte, 3'b0, overrun, sync_found, pid_valid, fifo_wr, rx_error}, 32'h0);
        rst = 1'b0;
        rx_active = 1'b0;

        repeat (4) tick();
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_receiver.md
Name: byte_receiver

Overview:
- Receive-side counterpart of the transmitter byte register.
- Accepts decoded serial bits LSB-first (one per `bit_valid` strobe) and hunts for the sync byte.
- Assembles the bytes that follow. Byte 1 after sync is handed to the receive FSM as the PID; later bytes are written to the receive FIFO.
- Sits between the bit-level decoder (NRZI/unstuff) and the RX FIFO / RX control FSM.

Parameters:
- SYNC_BYTE, 8'h80, sync pattern value (arrives LSB-first as 0,0,0,0,0,0,0,1).
- HUNT_LIMIT, 32, maximum bits accepted in HUNT without a sync match before abort (range 8..255).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- rx_active  input  1  packet in progress; low forces IDLE.
- bit_valid  input  1  one-cycle strobe, `bit_in` valid this cycle.
- bit_in  input  1  decoded serial data bit.
- eop  input  1  one-cycle end-of-packet strobe.
- fifo_full  input  1  RX FIFO cannot accept a write.
- rx_byte  output  8  last assembled byte (held until the next byte completes).
- pid_valid  output  1  one-cycle pulse: `rx_byte` is the PID.
- fifo_wr  output  1  one-cycle pulse: write `rx_byte` to the FIFO.
- sync_found  output  1  one-cycle pulse on sync match.
- rx_error  output  1  one-cycle pulse: partial byte at EOP, or hunt timeout.
- overrun  output  1  sticky: a data byte was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, `rst`=1 at a clock edge):
  - state=IDLE; shift reg, `rx_byte`, bit_cnt and hunt_cnt = 0.
  - All pulse outputs = 0; `overrun` = 0.
- Shift rule: on each `bit_valid` in HUNT/PID/DATA, sr <= {bit_in, sr[7:1]} (LSB-first, mirrors the transmitter's LSB-first shift).
- States: IDLE, HUNT, PID, DATA.
- IDLE:
  - `rx_active`=1 -> HUNT next cycle.
  - On that transition: sr, hunt_cnt and bit_cnt cleared; `overrun` cleared.
  - `bit_valid`/`eop` ignored.
- HUNT:
  - Each `bit_valid` increments hunt_cnt.
  - If the post-shift sr == SYNC_BYTE: `sync_found` pulses the next cycle, bit_cnt=0, go to PID.
  - Otherwise, if hunt_cnt reaches HUNT_LIMIT: `rx_error` pulses, go to IDLE.
  - `eop` in HUNT -> IDLE, no error.
- PID/DATA:
  - Each `bit_valid` increments 3-bit bit_cnt.
  - On the 8th bit (bit_cnt==7 with `bit_valid`), the following happen the next cycle:
    - `rx_byte` <= post-shift sr; bit_cnt wraps to 0.
    - In PID: `pid_valid` pulses; go to DATA.
    - In DATA with `fifo_full`=0: `fifo_wr` pulses.
    - In DATA with `fifo_full`=1: no write; `overrun` <= 1 (sticky until the next IDLE->HUNT).
- `eop` in PID/DATA:
  - bit_cnt!=0 -> `rx_error` pulses; go to IDLE.
  - bit_cnt==0 -> IDLE, no error.
- Simultaneous `eop` and 8th-bit `bit_valid`: the byte completes first (pid_valid/fifo_wr as above); `eop` then sees bit_cnt==0, so no error; go to IDLE.
- `rx_active`=0 in any non-IDLE state:
  - Abort to IDLE; no `fifo_wr`/`pid_valid`/`rx_error` generated that cycle.
  - `rx_byte` and `overrun` retain their values.
- Latency: every output pulse occurs exactly 1 cycle after the qualifying `bit_valid`/`eop` edge. All outputs are registered.
- Back-to-back `bit_valid` every cycle is supported, so at most one pulse per cycle per output.
- `rst` mid-packet: same as power-on reset; any partial byte is discarded.

Test Plan:
1. Reset then `rx_active`=1; bits 0,0,0,0,0,0,0,1 -> `sync_found` pulse 1 cycle after the 8th bit; state PID.
2. After sync, bits of 8'hA5 LSB-first (1,0,1,0,0,1,0,1), then 8'h3C -> `pid_valid` with `rx_byte`=8'hA5; then `fifo_wr` with `rx_byte`=8'h3C; assert `eop` on the bit_cnt==0 boundary -> IDLE, `rx_error`=0.
3. After PID, `fifo_full`=1 during byte 8'h12 -> no `fifo_wr`, `overrun`=1, `rx_byte`=8'h12. Next packet's IDLE->HUNT clears `overrun`.
4. After PID, 5 bits then `eop` -> `rx_error` 1-cycle pulse, IDLE, no `fifo_wr`.
5. HUNT with 32 zero bits (HUNT_LIMIT=32) -> `rx_error` pulse after the 32nd bit, IDLE. Also: `eop` coincident with the 8th data bit of 8'hFF -> `fifo_wr` with 8'hFF and no `rx_error`.
6. Drop `rx_active` after 3 data bits -> IDLE, no pulses. Also: `rst`=1 mid-byte -> all outputs 0 next cycle.
